// File: rtl/flopenr_flopr_if.sv
// Bundle of the flag, COM and PC register signals between a controller and flopenr_flopr.
//   flags_en : load enable for the ALU flag register
//   flags_d  : ALU flags to capture (F bits)
//   com_set  : sets the sticky COM flag
//   start    : run enable for the PC register
//   pc_d     : next program-counter value (I bits)
//   flags_q  : registered ALU flags
//   com_q    : sticky COM flag
//   pc_q     : registered program counter
interface flopenr_flopr_if #(
  parameter int unsigned I = 32,
  parameter int unsigned F = 2
) ();

  logic         flags_en;
  logic [F-1:0] flags_d;
  logic         com_set;
  logic         start;
  logic [I-1:0] pc_d;
  logic [F-1:0] flags_q;
  logic         com_q;
  logic [I-1:0] pc_q;

  // Controller side: drives enables and data, observes register outputs.
  modport master (
    output flags_en,
    output flags_d,
    output com_set,
    output start,
    output pc_d,
    input  flags_q,
    input  com_q,
    input  pc_q
  );

  // Register-block side.
  modport slave (
    input  flags_en,
    input  flags_d,
    input  com_set,
    input  start,
    input  pc_d,
    output flags_q,
    output com_q,
    output pc_q
  );

endinterface

// File: rtl/flopenr_flopr.sv
// Three independent registers sharing one clock and a synchronous active-low reset:
//   - ALU flag register (F bits), loaded when flags_en=1
//   - sticky COM flag, set by com_set=1, cleared only by reset
//   - program counter (I bits), loaded from pc_d when start=1, otherwise held
// Ports:
//   clk   : rising-edge clock for every register
//   reset : synchronous active-low reset, clears all registers at the next rising edge
//   bus   : flopenr_flopr_if slave modport carrying enables, data and register outputs
// All outputs come straight from flip-flops.
module flopenr_flopr #(
  parameter int unsigned I = 32,
  parameter int unsigned F = 2
) (
  input  logic            clk,
  input  logic            reset,
  flopenr_flopr_if.slave  bus
);

  logic [F-1:0] flags_next;
  logic         com_next;
  logic [I-1:0] pc_next;

  // Next-state logic; reset wins over every enable.
  always_comb begin
    flags_next = bus.flags_q;
    com_next   = bus.com_q;
    pc_next    = bus.pc_q;
    if (!reset) begin
      flags_next = '0;
      com_next   = 1'b0;
      pc_next    = '0;
    end else begin
      if (bus.flags_en) flags_next = bus.flags_d;
      if (bus.com_set)  com_next   = 1'b1;
      if (bus.start)    pc_next    = bus.pc_d;
    end
  end

  always_ff @(posedge clk) begin
    bus.flags_q <= flags_next;
    bus.com_q   <= com_next;
    bus.pc_q    <= pc_next;
  end

endmodule

// File: tb/tb_flopenr_flopr.sv
// Directed-vector bench for flopenr_flopr with hand-computed expected values.
module tb_flopenr_flopr;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  flopenr_flopr_if #(.I(32), .F(2)) bus ();

  flopenr_flopr #(.I(32), .F(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc, input logic [1:0] fl,
                           input logic com);
    check({tag, ".pc"}, bus.pc_q, pc);
    check({tag, ".flags"}, {30'd0, bus.flags_q}, {30'd0, fl});
    check({tag, ".com"}, {31'd0, bus.com_q}, {31'd0, com});
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Reset held for two edges with every enable active.
    reset        = 1'b0;
    bus.start    = 1'b1;
    bus.flags_en = 1'b1;
    bus.com_set  = 1'b1;
    bus.pc_d     = 32'h1234;
    bus.flags_d  = 2'b11;
    tick();
    check_all("rst1", 32'h0, 2'b00, 1'b0);
    tick();
    check_all("rst2", 32'h0, 2'b00, 1'b0);

    // PC loads with one-edge latency, including all-ones.
    reset        = 1'b1;
    bus.flags_en = 1'b0;
    bus.com_set  = 1'b0;
    bus.pc_d     = 32'h4;
    tick();
    check_all("pc4", 32'h4, 2'b00, 1'b0);
    bus.pc_d = 32'h8;
    tick();
    check("pc8", bus.pc_q, 32'h8);
    bus.pc_d = 32'hFFFF_FFFF;
    tick();
    check("pc_ones", bus.pc_q, 32'hFFFF_FFFF);

    // Hold with start=0, then load.
    bus.start = 1'b0;
    bus.pc_d  = 32'h10;
    tick();
    check("pc_hold1", bus.pc_q, 32'hFFFF_FFFF);
    tick();
    check("pc_hold2", bus.pc_q, 32'hFFFF_FFFF);
    bus.start = 1'b1;
    tick();
    check("pc_10", bus.pc_q, 32'h10);
    bus.start = 1'b0;

    // Flag register load and hold.
    bus.flags_en = 1'b1;
    bus.flags_d  = 2'b01;
    tick();
    check_all("fl01", 32'h10, 2'b01, 1'b0);
    bus.flags_en = 1'b0;
    bus.flags_d  = 2'b10;
    tick();
    check("fl_hold1", {30'd0, bus.flags_q}, 32'h1);
    tick();
    check("fl_hold2", {30'd0, bus.flags_q}, 32'h1);
    bus.flags_en = 1'b1;
    bus.flags_d  = 2'b11;
    tick();
    check("fl11", {30'd0, bus.flags_q}, 32'h3);
    bus.flags_en = 1'b0;

    // Sticky COM: one-cycle pulse, then held for 5 cycles.
    bus.com_set = 1'b1;
    tick();
    check_all("com_set", 32'h10, 2'b11, 1'b1);
    bus.com_set = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("com_sticky", {31'd0, bus.com_q}, 32'h1);
    end
    check_all("indep", 32'h10, 2'b11, 1'b1);

    // Reset priority over concurrent loads.
    reset        = 1'b0;
    bus.start    = 1'b1;
    bus.pc_d     = 32'h55;
    bus.flags_en = 1'b1;
    bus.flags_d  = 2'b10;
    bus.com_set  = 1'b1;
    tick();
    check_all("rst_prio", 32'h0, 2'b00, 1'b0);

    // First edge after reset release loads normally.
    reset        = 1'b1;
    bus.pc_d     = 32'h20;
    bus.flags_en = 1'b0;
    bus.com_set  = 1'b0;
    tick();
    check_all("post_rst", 32'h20, 2'b00, 1'b0);
    bus.start = 1'b0;

    // Reset asserted between edges has no effect until the edge.
    #2;
    reset = 1'b0;
    #2;
    check("rst_mid_hold", bus.pc_q, 32'h20);
    tick();
    check("rst_mid_clr", bus.pc_q, 32'h0);

    // Reset released between edges: load happens only at the edge.
    #2;
    reset     = 1'b1;
    bus.start = 1'b1;
    bus.pc_d  = 32'h7;
    #1;
    check("rel_mid_hold", bus.pc_q, 32'h0);
    tick();
    check("rel_load", bus.pc_q, 32'h7);

    // Glitch on start between edges is ignored.
    bus.start = 1'b0;
    #1;
    bus.start = 1'b1;
    bus.pc_d  = 32'h99;
    #2;
    bus.start = 1'b0;
    tick();
    check("glitch", bus.pc_q, 32'h7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flopenr_flopr.md
FLOPENR_FLOPR -- requirements
Module: flopenr_flopr

Interface
REQ-001 Parameter I, default 32: program-counter register width in bits.
REQ-002 Parameter F, default 2: ALU flag register width in bits.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock for every register.
REQ-005 reset  input  1  synchronous active-low reset: 0 clears every register at the next rising clk edge.
REQ-006 flags_en  input  1  load enable for the ALU flag register.
REQ-007 flags_d  input  F  ALU flags to capture.
REQ-008 com_set  input  1  sets the sticky COM flag.
REQ-009 start  input  1  run enable for the PC register.
REQ-010 pc_d  input  I  next program-counter value.
REQ-011 flags_q  output  F  registered ALU flags.
REQ-012 com_q  output  1  sticky COM flag.
REQ-013 pc_q  output  I  registered program counter.

Function
REQ-014 All outputs SHALL be driven only by flip-flops; no combinational input-to-output path.
REQ-015 Flag register: at a rising clk edge with reset=1 and flags_en=1, flags_q SHALL take flags_d.
REQ-016 Flag register: when flags_en=0, flags_q SHALL hold its value.
REQ-017 COM flag: at a rising clk edge with reset=1 and com_set=1, com_q SHALL become 1.
REQ-018 COM flag: when com_set=0, com_q SHALL hold; once set it SHALL clear only through reset.
REQ-019 PC register: at a rising clk edge with reset=1 and start=1, pc_q SHALL take pc_d.
REQ-020 PC register: when start=0, pc_q SHALL hold its value and SHALL NOT increment or change in any other way.
REQ-021 Load latency for all three registers SHALL be exactly one clk edge, and each new value SHALL be visible immediately after that edge.
REQ-022 Reset SHALL take priority over flags_en, com_set and start when they are asserted in the same cycle.
REQ-023 The three registers SHALL be independent: asserting one enable SHALL NOT affect the other registers.
REQ-024 pc_d and flags_d SHALL be captured bit-exactly with no arithmetic, sign extension or truncation; full-scale values such as all-ones SHALL load unchanged.
REQ-025 Inputs SHALL be sampled only at rising clk edges; glitches between edges SHALL have no effect.

Reset
REQ-026 While reset=0 at a rising clk edge, flags_q SHALL become 0, com_q SHALL become 0 and pc_q SHALL become 0.
REQ-027 Reset SHALL be synchronous: asserting or deasserting it between clk edges SHALL NOT change any output until the next rising edge.
REQ-028 Reset asserted mid-operation, with start=1 or com_q=1, SHALL clear all registers on that edge, discarding any concurrent load.
REQ-029 After reset returns to 1, the first rising edge SHALL load normally according to the current enables.

Verification
REQ-030 Apply reset=0 for 2 cycles with start=1, flags_en=1, com_set=1, pc_d=0x1234 and flags_d=2'b11 -> pc_q=0, flags_q=0 and com_q=0 throughout.
REQ-031 Set reset=1, start=1, and drive pc_d=4, 8, then 0xFFFFFFFF on successive edges -> pc_q=4, 8, then 0xFFFFFFFF, each one edge after its input.
REQ-032 Set start=0 and change pc_d to 0x10 -> pc_q stays at its last value; set start=1 -> pc_q=0x10 after one edge.
REQ-033 Drive flags_d=2'b01 with flags_en=1, then flags_d=2'b10 with flags_en=0 -> flags_q=2'b01 and stays 2'b01.
REQ-034 Pulse com_set=1 for one cycle, then hold com_set=0 for 5 cycles -> com_q=1 and stays 1; then reset=0 for one edge -> com_q=0.
REQ-035 Assert reset=0 between clk edges while pc_q=0x20 -> pc_q stays 0x20 until the next rising edge, then becomes 0.
